// File: rtl/screen_sequencer.sv
// ---------------------------------------------------------------------------
// screen_sequencer
//   Top-level screen controller for the VGA game. Chooses which full-screen
//   renderer (title / play / gameover) drives the pixel mux and fades between
//   screens with a 4-bit brightness factor. Every visible change is applied on
//   the frame tick (start of vertical blank), so no frame tears.
//
// Ports
//   vga_clk      in   pixel clock, all logic on posedge
//   reset_n      in   async active-low reset (released synchronously)
//   DrawX/DrawY  in   current pixel position from the VGA controller
//   start_btn    in   raw push-button, asynchronous to vga_clk
//   player_dead  in   level from game logic, synchronous to vga_clk
//   screen_sel   out  0=title, 1=play, 2=gameover
//   brightness   out  15=full colour .. 0=black
//   game_run     out  high while in PLAY (one-cycle registered lag)
//   frame_tick   out  one-cycle pulse at start of vertical blank
// ---------------------------------------------------------------------------
module screen_sequencer #(
   parameter int FADE_FRAMES = 2,
   parameter int HOLD_FRAMES = 180,
   parameter int VBLANK_Y    = 480
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   input  logic       start_btn,
   input  logic       player_dead,
   output logic [1:0] screen_sel,
   output logic [3:0] brightness,
   output logic       game_run,
   output logic       frame_tick
);

   localparam logic [2:0] S_TITLE    = 3'd0;
   localparam logic [2:0] S_PLAY     = 3'd1;
   localparam logic [2:0] S_GAMEOVER = 3'd2;
   localparam logic [2:0] S_FADE_OUT = 3'd3;
   localparam logic [2:0] S_FADE_IN  = 3'd4;

   localparam logic [1:0] SEL_TITLE    = 2'd0;
   localparam logic [1:0] SEL_PLAY     = 2'd1;
   localparam logic [1:0] SEL_GAMEOVER = 2'd2;

   localparam logic [3:0] FADE_LAST  = 4'(FADE_FRAMES - 1);
   localparam logic [9:0] HOLD_LAST  = 10'(HOLD_FRAMES - 1);
   localparam logic [9:0] VBLANK_ROW = 10'(VBLANK_Y);

   // Reset: asserts immediately, releases two clocks later so every flop
   // leaves reset on the same edge.
   logic r_rst_meta, r_rst_sync;
   logic w_rst_n;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= r_rst_meta;
      end
   end

   assign w_rst_n = r_rst_sync;

   // Frame tick: rising edge of the "first blanked pixel" match, so a
   // stalled DrawX/DrawY produces a single pulse.
   logic w_vblank_hit;
   logic r_hit_d;
   logic r_frame_tick;

   assign w_vblank_hit = (DrawX == 10'd0) && (DrawY == VBLANK_ROW);

   always_ff @(posedge vga_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_hit_d      <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_hit_d      <= w_vblank_hit;
         r_frame_tick <= w_vblank_hit & ~r_hit_d;
      end
   end

   // Start button: two-flop synchroniser plus one delay flop for edge detect.
   logic r_btn_s1, r_btn_s2, r_btn_d;
   logic w_start_evt;

   always_ff @(posedge vga_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_btn_s1 <= 1'b0;
         r_btn_s2 <= 1'b0;
         r_btn_d  <= 1'b0;
      end else begin
         r_btn_s1 <= start_btn;
         r_btn_s2 <= r_btn_s1;
         r_btn_d  <= r_btn_s2;
      end
   end

   assign w_start_evt = r_btn_s2 & ~r_btn_d;

   logic [2:0] r_state;
   logic [1:0] r_target;
   logic [1:0] r_sel;
   logic [3:0] r_bright;
   logic [3:0] r_fcnt;
   logic [9:0] r_hold;
   logic       r_pend;
   logic       r_game_run;
   logic       w_accepting;
   logic       w_pend;
   logic [2:0] w_target_state;

   // Only TITLE and GAMEOVER listen to start; anywhere else the flag is dropped.
   assign w_accepting = (r_state == S_TITLE) || (r_state == S_GAMEOVER);
   // An event landing on the tick cycle itself still counts for that tick.
   assign w_pend      = r_pend | w_start_evt;

   always_ff @(posedge vga_clk or negedge w_rst_n) begin
      if (!w_rst_n)          r_pend <= 1'b0;
      else if (!w_accepting) r_pend <= 1'b0;
      else if (r_frame_tick) r_pend <= 1'b0;
      else if (w_start_evt)  r_pend <= 1'b1;
   end

   always_comb begin
      w_target_state = S_TITLE;
      case (r_target)
         SEL_PLAY:     w_target_state = S_PLAY;
         SEL_GAMEOVER: w_target_state = S_GAMEOVER;
         default:      w_target_state = S_TITLE;
      endcase
   end

   // Main sequencer: nothing moves except on a frame tick.
   always_ff @(posedge vga_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state  <= S_TITLE;
         r_target <= SEL_TITLE;
         r_sel    <= SEL_TITLE;
         r_bright <= 4'hF;
         r_fcnt   <= 4'd0;
         r_hold   <= 10'd0;
      end else if (r_frame_tick) begin
         case (r_state)
            S_TITLE: begin
               if (w_pend) begin
                  r_state  <= S_FADE_OUT;
                  r_target <= SEL_PLAY;
                  r_fcnt   <= 4'd0;
               end
            end
            S_PLAY: begin
               if (player_dead) begin
                  r_state  <= S_FADE_OUT;
                  r_target <= SEL_GAMEOVER;
                  r_fcnt   <= 4'd0;
               end
            end
            S_GAMEOVER: begin
               // Start and timeout together still yield one transition.
               if (w_pend || (r_hold == HOLD_LAST)) begin
                  r_state  <= S_FADE_OUT;
                  r_target <= SEL_TITLE;
                  r_fcnt   <= 4'd0;
               end else begin
                  r_hold <= r_hold + 10'd1;
               end
            end
            S_FADE_OUT: begin
               if (r_fcnt == FADE_LAST) begin
                  r_fcnt <= 4'd0;
                  if (r_bright <= 4'd1) begin
                     // Swap renderers on the tick the screen goes black.
                     r_bright <= 4'd0;
                     r_sel    <= r_target;
                     r_state  <= S_FADE_IN;
                  end else begin
                     r_bright <= r_bright - 4'd1;
                  end
               end else begin
                  r_fcnt <= r_fcnt + 4'd1;
               end
            end
            S_FADE_IN: begin
               if (r_fcnt == FADE_LAST) begin
                  r_fcnt <= 4'd0;
                  if (r_bright >= 4'd14) begin
                     r_bright <= 4'hF;
                     r_state  <= w_target_state;
                     r_hold   <= 10'd0;
                  end else begin
                     r_bright <= r_bright + 4'd1;
                  end
               end else begin
                  r_fcnt <= r_fcnt + 4'd1;
               end
            end
            default: begin
               r_state  <= S_TITLE;
               r_sel    <= SEL_TITLE;
               r_bright <= 4'hF;
               r_fcnt   <= 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge vga_clk or negedge w_rst_n) begin
      if (!w_rst_n) r_game_run <= 1'b0;
      else          r_game_run <= (r_state == S_PLAY);
   end

   assign screen_sel = r_sel;
   assign brightness = r_bright;
   assign game_run   = r_game_run;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_screen_sequencer.sv
// ---------------------------------------------------------------------------
// tb_screen_sequencer
//   Drives a shortened raster (4 columns x 6 rows, rows 476..481, so the
//   blanking point DrawX=0/DrawY=480 recurs every 24 clocks) and follows the
//   game through title -> play -> gameover -> title plus a reset mid-fade.
//   Expected (screen_sel, brightness, frames-since-previous-change) steps are
//   queued when stimulus is applied and popped whenever the outputs change.
// ---------------------------------------------------------------------------
module tb_screen_sequencer;

   typedef struct {
      logic [1:0] sel;
      logic [3:0] br;
      int         ticks;
   } exp_t;

   logic       vga_clk;
   logic       reset_n;
   logic [9:0] DrawX, DrawY;
   logic       start_btn;
   logic       player_dead;
   logic [1:0] screen_sel;
   logic [3:0] brightness;
   logic       game_run;
   logic       frame_tick;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   int   mark_seq = 0;
   bit   mon_en   = 1'b1;
   bit   stall    = 1'b0;
   logic [9:0] stall_x = '0, stall_y = '0;
   int   sx = 0, sy = 0;

   assign DrawX = stall ? stall_x : 10'(sx);
   assign DrawY = stall ? stall_y : 10'(476 + sy);

   screen_sequencer #(.FADE_FRAMES(2), .HOLD_FRAMES(4), .VBLANK_Y(480)) dut (
      .vga_clk     (vga_clk),
      .reset_n     (reset_n),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .start_btn   (start_btn),
      .player_dead (player_dead),
      .screen_sel  (screen_sel),
      .brightness  (brightness),
      .game_run    (game_run),
      .frame_tick  (frame_tick)
   );

   initial begin
      vga_clk = 1'b0;
      forever #5 vga_clk = ~vga_clk;
   end

   task automatic scan_gen();
      forever begin
         @(negedge vga_clk);
         if (sx == 3) begin
            sx = 0;
            sy = (sy == 5) ? 0 : sy + 1;
         end else begin
            sx = sx + 1;
         end
      end
   endtask

   task automatic sb_monitor();
      logic [5:0] prev;
      int   ticks;
      int   seen;
      exp_t e;
      prev  = 6'h0F;
      ticks = 0;
      seen  = 0;
      forever begin
         @(negedge vga_clk);
         if (!reset_n || !mon_en) begin
            prev  = {screen_sel, brightness};
            ticks = 0;
         end else begin
            if (seen != mark_seq) begin
               seen  = mark_seq;
               ticks = 0;
            end
            if (frame_tick) ticks++;
            if ({screen_sel, brightness} != prev) begin
               prev = {screen_sel, brightness};
               n_checks++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL sb_unexpected: got sel=%0d br=%0d, no change expected", screen_sel, brightness);
               end else begin
                  e = sb.pop_front();
                  if (screen_sel !== e.sel || brightness !== e.br || ticks != e.ticks) begin
                     n_fail++;
                     $display("FAIL sb_step: got sel=%0d br=%0d after %0d ticks, want sel=%0d br=%0d after %0d ticks",
                              screen_sel, brightness, ticks, e.sel, e.br, e.ticks);
                  end
               end
               ticks = 0;
            end
         end
      end
   endtask

   task automatic push_exp(input logic [1:0] sel, input int br, input int ticks);
      exp_t e;
      e.sel = sel; e.br = 4'(br); e.ticks = ticks;
      sb.push_back(e);
   endtask

   // Queue a full fade: out from `from_sel` to black (sel swaps at 0), then in.
   task automatic push_fade(input logic [1:0] from_sel, input logic [1:0] to_sel, input int first_ticks);
      for (int b = 14; b >= 0; b--)
         push_exp((b == 0) ? to_sel : from_sel, b, (b == 14) ? first_ticks : 2);
      for (int b = 1; b <= 15; b++)
         push_exp(to_sel, b, 2);
   endtask

   task automatic sync_to_tick(input string name);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge vga_clk);
         if (frame_tick) got = 1'b1;
      end
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL %s_tick_timeout: no frame_tick in 100 clk", name);
      end
   endtask

   task automatic press_start();
      start_btn = 1'b1;
      repeat (3) @(negedge vga_clk);
      start_btn = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start_btn = 1'b0; player_dead = 1'b0;
      repeat (3) @(negedge vga_clk);
      n_checks++;
      if (screen_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", screen_sel); end
      n_checks++;
      if (brightness !== 4'd15) begin n_fail++; $display("FAIL reset_br: got %0d want 15", brightness); end
      n_checks++;
      if (game_run !== 1'b0) begin n_fail++; $display("FAIL reset_run: got %0b want 0", game_run); end
      n_checks++;
      if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %0b want 0", frame_tick); end
      reset_n = 1'b1;
      repeat (4) @(negedge vga_clk);
   endtask

   task automatic test_tick_stall();
      int cnt;
      stall_x = 10'd5; stall_y = 10'd0; stall = 1'b1;
      repeat (3) @(negedge vga_clk);
      stall_x = 10'd0; stall_y = 10'd480;
      cnt = 0;
      repeat (12) begin
         @(negedge vga_clk);
         if (frame_tick) cnt++;
      end
      stall = 1'b0;
      n_checks++;
      if (cnt != 1) begin n_fail++; $display("FAIL tick_stall: got %0d pulses want 1", cnt); end
   endtask

   task automatic test_title_to_play();
      bit done, pulsed;
      sync_to_tick("t2p");
      repeat (3) @(negedge vga_clk);
      mark_seq++;
      push_fade(2'd0, 2'd1, 3);
      press_start();
      done = 1'b0; pulsed = 1'b0;
      for (int i = 0; i < 70 * 24 && !done; i++) begin
         @(negedge vga_clk);
         if (screen_sel == 2'd1 && brightness == 4'd15) done = 1'b1;
         else if (screen_sel == 2'd1 && brightness == 4'd5 && !pulsed) begin
            pulsed = 1'b1;
            press_start();
         end
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL t2p_timeout: sel=%0d br=%0d", screen_sel, brightness);
      end
      n_checks++;
      if (game_run !== 1'b0) begin n_fail++; $display("FAIL t2p_run_lag: got %0b want 0", game_run); end
      @(negedge vga_clk);
      n_checks++;
      if (game_run !== 1'b1) begin n_fail++; $display("FAIL t2p_run: got %0b want 1", game_run); end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL t2p_left: got %0d queued want 0", sb.size()); end
      n_checks++;
      if (dut.r_pend !== 1'b0) begin n_fail++; $display("FAIL t2p_pend: got %0b want 0", dut.r_pend); end
   endtask

   task automatic test_ignored_play();
      press_start();
      repeat (72) @(negedge vga_clk);
      n_checks++;
      if (screen_sel !== 2'd1) begin n_fail++; $display("FAIL ign_sel: got %0d want 1", screen_sel); end
      n_checks++;
      if (brightness !== 4'd15) begin n_fail++; $display("FAIL ign_br: got %0d want 15", brightness); end
      n_checks++;
      if (game_run !== 1'b1) begin n_fail++; $display("FAIL ign_run: got %0b want 1", game_run); end
      n_checks++;
      if (dut.r_pend !== 1'b0) begin n_fail++; $display("FAIL ign_pend: got %0b want 0", dut.r_pend); end
   endtask

   task automatic test_death();
      bit done;
      sync_to_tick("death");
      repeat (3) @(negedge vga_clk);
      mark_seq++;
      push_fade(2'd1, 2'd2, 3);
      player_dead = 1'b1;
      sync_to_tick("death_fall");
      @(negedge vga_clk);
      n_checks++;
      if (game_run !== 1'b1) begin n_fail++; $display("FAIL death_run_hold: got %0b want 1", game_run); end
      @(negedge vga_clk);
      n_checks++;
      if (game_run !== 1'b0) begin n_fail++; $display("FAIL death_run_fall: got %0b want 0", game_run); end
      done = 1'b0;
      for (int i = 0; i < 70 * 24 && !done; i++) begin
         @(negedge vga_clk);
         if (screen_sel == 2'd2 && brightness == 4'd15) done = 1'b1;
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL death_timeout: sel=%0d br=%0d", screen_sel, brightness);
      end
      player_dead = 1'b0;
      @(negedge vga_clk);
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL death_left: got %0d queued want 0", sb.size()); end
   endtask

   task automatic test_auto_return();
      bit done;
      // 4 hold ticks, then 2 more before the first step down.
      push_fade(2'd2, 2'd0, 6);
      done = 1'b0;
      for (int i = 0; i < 80 * 24 && !done; i++) begin
         @(negedge vga_clk);
         if (screen_sel == 2'd0 && brightness == 4'd15) done = 1'b1;
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL auto_timeout: sel=%0d br=%0d", screen_sel, brightness);
      end
      @(negedge vga_clk);
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL auto_left: got %0d queued want 0", sb.size()); end
      n_checks++;
      if (game_run !== 1'b0) begin n_fail++; $display("FAIL auto_run: got %0b want 0", game_run); end
   endtask

   task automatic test_reset_mid_fade();
      bit done;
      mon_en = 1'b0;
      sync_to_tick("rst");
      repeat (3) @(negedge vga_clk);
      press_start();
      done = 1'b0;
      for (int i = 0; i < 40 * 24 && !done; i++) begin
         @(negedge vga_clk);
         if (brightness == 4'd10) done = 1'b1;
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL rst_fade_timeout: br=%0d", brightness);
      end
      #3 reset_n = 1'b0;
      #1;
      n_checks++;
      if (screen_sel !== 2'd0) begin n_fail++; $display("FAIL rst_sel: got %0d want 0", screen_sel); end
      n_checks++;
      if (brightness !== 4'd15) begin n_fail++; $display("FAIL rst_br: got %0d want 15", brightness); end
      n_checks++;
      if (game_run !== 1'b0) begin n_fail++; $display("FAIL rst_run: got %0b want 0", game_run); end
      @(negedge vga_clk);
      reset_n = 1'b1;
      repeat (4) @(negedge vga_clk);
      mon_en = 1'b1;
      repeat (96) @(negedge vga_clk);
      n_checks++;
      if (brightness !== 4'd15) begin n_fail++; $display("FAIL rst_resume_br: got %0d want 15", brightness); end
      n_checks++;
      if (screen_sel !== 2'd0) begin n_fail++; $display("FAIL rst_resume_sel: got %0d want 0", screen_sel); end
   endtask

   initial begin
      reset_n = 1'b0; start_btn = 1'b0; player_dead = 1'b0;
      fork
         scan_gen();
         sb_monitor();
      join_none
      test_reset();
      test_tick_stall();
      test_title_to_play();
      test_ignored_play();
      test_death();
      test_auto_return();
      test_reset_mid_fade();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
